// File: rtl/matrix_alu_seq.sv
// Sequential matrix ALU: streams in A (and B), computes one element or one MAC
// per cycle, and streams the saturated result matrix out row-major.
module matrix_alu_seq #(
   parameter int DATA_W = 8,
   parameter int MAX_N  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [2:0]        size,
   input  logic [DATA_W-1:0] scalar,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              ovf
);

   // state     | meaning
   // S_IDLE    | waiting for start, command fields latched here
   // S_LOAD_A  | accepting N*N elements of A
   // S_LOAD_B  | accepting N*N elements of B (add/sub/mult only)
   // S_COMPUTE | one result element (or one MAC for multM) per cycle
   // S_OUT     | streaming R under out_valid/out_ready
   // S_FIN     | single done cycle, then back to idle
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD_A  = 3'd1;
   localparam logic [2:0] S_LOAD_B  = 3'd2;
   localparam logic [2:0] S_COMPUTE = 3'd3;
   localparam logic [2:0] S_OUT     = 3'd4;
   localparam logic [2:0] S_FIN     = 3'd5;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_MRS = 3'b011;
   localparam logic [2:0] OP_DET = 3'b100;
   localparam logic [2:0] OP_TRN = 3'b101;
   localparam logic [2:0] OP_NEG = 3'b110;
   localparam logic [2:0] OP_RST = 3'b111;

   localparam int AW    = 2*DATA_W + 3;
   localparam int DEPTH = MAX_N*MAX_N;
   localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic signed [AW-1:0] SAT_MAX = AW'((2**(DATA_W-1)) - 1);
   localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

   logic [2:0]               state_q, state_d;
   logic [2:0]               op_q, op_d;
   logic [2:0]               n_q, n_d;
   logic signed [DATA_W-1:0] scalar_q, scalar_d;
   logic [IW-1:0]            cnt_q, cnt_d;
   logic [2:0]               i_q, i_d, j_q, j_d, k_q, k_d;
   logic signed [AW-1:0]     acc_q, acc_d;
   logic                     err_q, err_d, ovf_q, ovf_d;

   logic signed [DATA_W-1:0] a_q [DEPTH];
   logic signed [DATA_W-1:0] b_q [DEPTH];
   logic signed [DATA_W-1:0] r_q [DEPTH];

   logic [2:0]           n_m1;
   logic [IW-1:0]        last_idx, idx_ij, idx_ji, idx_ik, idx_kj;
   logic                 need_b, bad_cmd, r_we, soft_clr, step_ij, sat_hit;
   logic signed [AW-1:0] acc_sum, res_w;
   logic [DATA_W-1:0]    r_val;

   assign n_m1     = n_q - 3'd1;
   assign last_idx = IW'(n_q) * IW'(n_q) - IW'(1);
   assign idx_ij   = IW'(i_q) * IW'(n_q) + IW'(j_q);
   assign idx_ji   = IW'(j_q) * IW'(n_q) + IW'(i_q);
   assign idx_ik   = IW'(i_q) * IW'(n_q) + IW'(k_q);
   assign idx_kj   = IW'(k_q) * IW'(n_q) + IW'(j_q);
   assign need_b   = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_MUL);
   assign bad_cmd  = (size == 3'd0) || (32'(size) > MAX_N) || (op == OP_DET);
   assign acc_sum  = acc_q + AW'(a_q[idx_ik]) * AW'(b_q[idx_kj]);

   // Wide result for the current element, then clamp to the element range
   always_comb begin
      res_w = '0;
      case (op_q)
         OP_ADD:  res_w = AW'(a_q[idx_ij]) + AW'(b_q[idx_ij]);
         OP_SUB:  res_w = AW'(a_q[idx_ij]) + (~AW'(b_q[idx_ij]) + AW'(1));
         OP_MUL:  res_w = acc_sum;
         OP_MRS:  res_w = AW'(scalar_q) * AW'(a_q[idx_ij]);
         OP_TRN:  res_w = AW'(a_q[idx_ji]);
         OP_NEG:  res_w = -AW'(a_q[idx_ij]);
         default: res_w = '0;
      endcase
      sat_hit = (res_w > SAT_MAX) || (res_w < SAT_MIN);
      if (res_w > SAT_MAX)      r_val = SAT_MAX[DATA_W-1:0];
      else if (res_w < SAT_MIN) r_val = SAT_MIN[DATA_W-1:0];
      else                      r_val = res_w[DATA_W-1:0];
   end

   // Sequencer next-state: command decode, load/compute/output counters
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      n_d      = n_q;
      scalar_d = scalar_q;
      cnt_d    = cnt_q;
      i_d      = i_q;
      j_d      = j_q;
      k_d      = k_q;
      acc_d    = acc_q;
      err_d    = err_q;
      ovf_d    = ovf_q;
      r_we     = 1'b0;
      soft_clr = 1'b0;
      step_ij  = 1'b0;
      case (state_q)
         S_IDLE: if (start) begin
            op_d     = op;
            n_d      = size;
            scalar_d = scalar;
            cnt_d    = '0;
            err_d    = 1'b0;
            ovf_d    = 1'b0;
            if (op == OP_RST) begin
               soft_clr = 1'b1;
               state_d  = S_FIN;
            end else if (bad_cmd) begin
               err_d   = 1'b1;
               state_d = S_FIN;
            end else begin
               state_d = S_LOAD_A;
            end
         end
         S_LOAD_A, S_LOAD_B: if (in_valid) begin
            if (cnt_q == last_idx) begin
               cnt_d   = '0;
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
               acc_d   = '0;
               state_d = (state_q == S_LOAD_A && need_b) ? S_LOAD_B : S_COMPUTE;
            end else begin
               cnt_d = cnt_q + IW'(1);
            end
         end
         S_COMPUTE: begin
            if (op_q == OP_MUL) begin
               if (k_q == n_m1) begin
                  r_we    = 1'b1;
                  step_ij = 1'b1;
                  acc_d   = '0;
                  k_d     = '0;
               end else begin
                  acc_d = acc_sum;
                  k_d   = k_q + 3'd1;
               end
            end else begin
               r_we    = 1'b1;
               step_ij = 1'b1;
            end
            if (r_we && sat_hit) ovf_d = 1'b1;
            if (step_ij) begin
               if (j_q == n_m1) begin
                  j_d = '0;
                  if (i_q == n_m1) begin
                     state_d = S_OUT;
                     cnt_d   = '0;
                  end else begin
                     i_d = i_q + 3'd1;
                  end
               end else begin
                  j_d = j_q + 3'd1;
               end
            end
         end
         S_OUT: if (out_ready) begin
            if (cnt_q == last_idx) state_d = S_FIN;
            else                   cnt_d   = cnt_q + IW'(1);
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Control registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         n_q      <= '0;
         scalar_q <= '0;
         cnt_q    <= '0;
         i_q      <= '0;
         j_q      <= '0;
         k_q      <= '0;
         acc_q    <= '0;
         err_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         n_q      <= n_d;
         scalar_q <= scalar_d;
         cnt_q    <= cnt_d;
         i_q      <= i_d;
         j_q      <= j_d;
         k_q      <= k_d;
         acc_q    <= acc_d;
         err_q    <= err_d;
         ovf_q    <= ovf_d;
      end
   end

   // Matrix buffers: no reset, contents are always rewritten before use
   always_ff @(posedge clk) begin
      if (soft_clr) begin
         for (int e = 0; e < DEPTH; e++) begin
            a_q[e] <= '0;
            b_q[e] <= '0;
            r_q[e] <= '0;
         end
      end else begin
         if (state_q == S_LOAD_A && in_valid) a_q[cnt_q] <= in_data;
         if (state_q == S_LOAD_B && in_valid) b_q[cnt_q] <= in_data;
         if (r_we)                            r_q[idx_ij] <= r_val;
      end
   end

   assign in_ready  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
   assign out_valid = (state_q == S_OUT);
   assign out_last  = out_valid && (cnt_q == last_idx);
   assign out_data  = out_valid ? r_q[cnt_q] : '0;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_FIN);
   assign err       = err_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_matrix_alu_seq.sv
// Directed bench for matrix_alu_seq: expected results are queued at issue
// time, and an independent monitor pops them on every output handshake.
module tb_matrix_alu_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [2:0] op;
   logic [2:0] size;
   logic [7:0] scalar;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;
   logic       busy;
   logic       done;
   logic       err;
   logic       ovf;

   matrix_alu_seq #(.DATA_W(8), .MAX_N(5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .size(size),
      .scalar(scalar), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .busy(busy), .done(done),
      .err(err), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      int d;
      bit last;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   bit   rdy_toggle = 1'b0;
   int   va [9];
   int   vb [9];
   int   ve [9];

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Output-side ready driver
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = rdy_toggle ? ~out_ready : 1'b1;
      end
   end

   // Monitor: pop and compare on each handshake, check hold while stalled
   initial begin
      bit held = 1'b0;
      int held_d = 0;
      int act;
      exp_t e;
      forever begin
         @(negedge clk);
         if (out_valid) begin
            act = $signed(out_data);
            if (held) chk("out_hold", act, held_d);
            if (out_ready) begin
               held = 1'b0;
               if (sb.size() == 0) begin
                  chk("unexpected_out", 1, 0);
               end else begin
                  e = sb.pop_front();
                  chk("out_data", act, e.d);
                  chk("out_last", int'(out_last), int'(e.last));
               end
            end else begin
               held   = 1'b1;
               held_d = act;
            end
         end else begin
            held = 1'b0;
         end
      end
   end

   task automatic do_cmd(input logic [2:0] o, input int n, input int s);
      start  = 1'b1;
      op     = o;
      size   = 3'(n);
      scalar = 8'(s);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic send(input int d);
      int t = 0;
      in_valid = 1'b1;
      in_data  = 8'(d);
      do begin
         @(negedge clk);
         t++;
      end while (!in_ready && t < 100);
      if (!in_ready) chk("in_ready_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input int exp_err, input int exp_ovf);
      int t = 0;
      while (t < 500) begin
         @(negedge clk);
         if (done) break;
         t++;
      end
      chk("done_seen", int'(done), 1);
      chk("err_at_done", int'(err), exp_err);
      chk("ovf_at_done", int'(ovf), exp_ovf);
      @(negedge clk);
      chk("done_one_cycle", int'(done), 0);
      chk("idle_after_fin", int'(busy), 0);
      @(posedge clk);
      #1;
   endtask

   // Push expected results, run one command end to end, check compute length
   task automatic issue(input logic [2:0] o, input int n, input int s,
                        input int exp_cyc, input int exp_ovf);
      int nn = n * n;
      int c = 0;
      exp_t e;
      for (int x = 0; x < nn; x++) begin
         e.d    = ve[x];
         e.last = (x == nn - 1);
         sb.push_back(e);
      end
      do_cmd(o, n, s);
      for (int x = 0; x < nn; x++) send(va[x]);
      if (o <= 3'b010) for (int x = 0; x < nn; x++) send(vb[x]);
      while (c < 300) begin
         @(negedge clk);
         if (out_valid) break;
         c++;
      end
      chk("compute_cycles", c, exp_cyc);
      wait_done(0, exp_ovf);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      op       = '0;
      size     = '0;
      scalar   = '0;
      in_valid = 1'b0;
      in_data  = '0;
      #2;
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err_ovf", int'({err, ovf}), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // addM N=2
      va = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
      vb = '{10, 20, 30, 40, 0, 0, 0, 0, 0};
      ve = '{11, 22, 33, 44, 0, 0, 0, 0, 0};
      issue(3'b000, 2, 0, 4, 0);

      // multM N=2
      va = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
      vb = '{5, 6, 7, 8, 0, 0, 0, 0, 0};
      ve = '{19, 22, 43, 50, 0, 0, 0, 0, 0};
      issue(3'b010, 2, 0, 8, 0);

      // oppM N=1 of -128 saturates
      va = '{-128, 0, 0, 0, 0, 0, 0, 0, 0};
      ve = '{127, 0, 0, 0, 0, 0, 0, 0, 0};
      issue(3'b110, 1, 0, 1, 1);

      // multMR 3*50 saturates
      va = '{50, 0, 0, 0, 0, 0, 0, 0, 0};
      ve = '{127, 0, 0, 0, 0, 0, 0, 0, 0};
      issue(3'b011, 1, 3, 1, 1);

      // subM N=2 with saturation at both ends
      va = '{5, -100, 0, 127, 0, 0, 0, 0, 0};
      vb = '{3, 100, 1, -1, 0, 0, 0, 0, 0};
      ve = '{2, -128, -1, 127, 0, 0, 0, 0, 0};
      issue(3'b001, 2, 0, 4, 1);

      // transM N=3 under a toggling out_ready
      rdy_toggle = 1'b1;
      va = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
      ve = '{1, 4, 7, 2, 5, 8, 3, 6, 9};
      issue(3'b101, 3, 0, 9, 0);
      rdy_toggle = 1'b0;

      // Rejected commands: oversize, then detM
      do_cmd(3'b000, 6, 0);
      @(negedge clk);
      chk("oversize_done", int'(done), 1);
      chk("oversize_err", int'(err), 1);
      chk("oversize_in_ready", int'(in_ready), 0);
      @(negedge clk);
      chk("oversize_idle", int'({busy, done, in_ready}), 0);
      chk("oversize_err_hold", int'(err), 1);
      @(posedge clk);
      #1;
      do_cmd(3'b100, 2, 0);
      @(negedge clk);
      chk("detm_done", int'(done), 1);
      chk("detm_err", int'(err), 1);
      chk("detm_in_ready", int'(in_ready), 0);
      @(posedge clk);
      #1;

      // Soft reset op clears err
      do_cmd(3'b111, 2, 0);
      @(negedge clk);
      chk("softrst_done", int'(done), 1);
      chk("softrst_err_ovf", int'({err, ovf}), 0);
      chk("softrst_in_ready", int'(in_ready), 0);
      @(posedge clk);
      #1;

      // Async reset after 3 of 4 A elements
      do_cmd(3'b000, 2, 0);
      send(1);
      send(2);
      send(3);
      in_valid = 1'b1;
      in_data  = 8'd4;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", int'(in_ready), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_outs", int'({out_valid, out_last, done, err, ovf}), 0);
      chk("midrst_out_data", int'(out_data), 0);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      va = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
      vb = '{10, 20, 30, 40, 0, 0, 0, 0, 0};
      ve = '{11, 22, 33, 44, 0, 0, 0, 0, 0};
      issue(3'b000, 2, 0, 4, 0);

      repeat (3) @(posedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
